aes_key_schedule: RTL and testbench



---
 rtl/aes_key_schedule.sv | 170 +++++++++++++++++
 tb/tb_aes_key_schedule.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_key_schedule.sv
// aes_key_schedule: sequential AES-128 key expansion (one round per clock) into an 11-entry round-key store.
// Optional macro AES_KEYSCHED_REG_OUT_EN registers rd_key/rd_valid for a one-cycle read latency.
module aes_key_schedule (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [127:0] key_in,
    input  logic         key_valid,
    output logic         key_ready,
    output logic         busy,
    output logic         keys_done,
    input  logic [3:0]   rd_idx,
    output logic [127:0] rd_key,
    output logic         rd_valid
);
    typedef enum logic [1:0] {IDLE, EXPAND, DONE} state_e;

    state_e       state_q, state_d;
    logic [127:0] store_q [0:10];
    logic [127:0] work_q, work_d;
    logic [7:0]   rcon_q, rcon_d;
    logic [3:0]   cnt_q, cnt_d;
    logic [3:0]   hi_q, hi_d;
    logic         loaded_q, loaded_d;
    logic         done_q, done_d;

    logic         wrEn;
    logic [3:0]   wrAddr;
    logic [127:0] wrData;
    logic [31:0]  w0, w1, w2, w3, temp, n0, n1, n2, n3;
    logic [127:0] nextKey;
    logic [127:0] rdKeyComb;
    logic         rdValidComb;

    function automatic logic [7:0] gfMul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // S-box as multiplicative inverse (x^254) followed by the AES affine transform.
    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] pw;
        logic [7:0] inv;
        pw  = x;
        inv = 8'h01;
        for (int k = 1; k < 8; k++) begin
            pw  = gfMul(pw, pw);
            inv = gfMul(inv, pw);
        end
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
               {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    assign w0      = work_q[127:96];
    assign w1      = work_q[95:64];
    assign w2      = work_q[63:32];
    assign w3      = work_q[31:0];
    assign temp    = {sbox(w3[23:16]), sbox(w3[15:8]), sbox(w3[7:0]), sbox(w3[31:24])}
                     ^ {rcon_q, 24'h0};
    assign n0      = w0 ^ temp;
    assign n1      = w1 ^ n0;
    assign n2      = w2 ^ n1;
    assign n3      = w3 ^ n2;
    assign nextKey = {n0, n1, n2, n3};

    always_comb begin
        state_d  = state_q;
        work_d   = work_q;
        rcon_d   = rcon_q;
        cnt_d    = cnt_q;
        hi_d     = hi_q;
        loaded_d = loaded_q;
        done_d   = done_q;
        wrEn     = 1'b0;
        wrAddr   = 4'd0;
        wrData   = nextKey;
        case (state_q)
            IDLE, DONE: begin
                if (key_valid) begin
                    state_d  = EXPAND;
                    work_d   = key_in;
                    rcon_d   = 8'h01;
                    cnt_d    = 4'd1;
                    hi_d     = 4'd0;
                    loaded_d = 1'b1;
                    done_d   = 1'b0;
                    wrEn     = 1'b1;
                    wrAddr   = 4'd0;
                    wrData   = key_in;
                end
            end
            EXPAND: begin
                work_d = nextKey;
                wrEn   = 1'b1;
                wrAddr = cnt_q;
                hi_d   = cnt_q;
                rcon_d = {rcon_q[6:0], 1'b0} ^ (rcon_q[7] ? 8'h1b : 8'h00);
                cnt_d  = cnt_q + 4'd1;
                if (cnt_q == 4'd10) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            work_q   <= '0;
            rcon_q   <= 8'h01;
            cnt_q    <= 4'd0;
            hi_q     <= 4'd0;
            loaded_q <= 1'b0;
            done_q   <= 1'b0;
            for (int i = 0; i < 11; i++) store_q[i] <= '0;
        end else begin
            state_q  <= state_d;
            work_q   <= work_d;
            rcon_q   <= rcon_d;
            cnt_q    <= cnt_d;
            hi_q     <= hi_d;
            loaded_q <= loaded_d;
            done_q   <= done_d;
            if (wrEn) store_q[wrAddr] <= wrData;
        end
    end

    assign key_ready = (state_q != EXPAND);
    assign busy      = (state_q == EXPAND);
    assign keys_done = done_q;

    // Indices past round 10 read as zero and never valid.
    always_comb begin
        rdKeyComb   = '0;
        rdValidComb = 1'b0;
        if (rd_idx <= 4'd10) begin
            rdKeyComb   = store_q[rd_idx];
            rdValidComb = loaded_q && (rd_idx <= hi_q);
        end
    end

`ifdef AES_KEYSCHED_REG_OUT_EN
    logic [127:0] rd_key_q;
    logic         rd_valid_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_key_q   <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            rd_key_q   <= rdKeyComb;
            rd_valid_q <= rdValidComb;
        end
    end

    assign rd_key   = rd_key_q;
    assign rd_valid = rd_valid_q;
`else
    assign rd_key   = rdKeyComb;
    assign rd_valid = rdValidComb;
`endif
endmodule

// File: tb/tb_aes_key_schedule.sv
// tb_aes_key_schedule: randomized and directed checks of aes_key_schedule against a FIPS-197 word-level model.
// Follows AES_KEYSCHED_REG_OUT_EN to know the read latency of the design under test.
module tb_aes_key_schedule;
`ifdef AES_KEYSCHED_REG_OUT_EN
    localparam int LAT = 1;
`else
    localparam int LAT = 0;
`endif
    localparam logic [7:0] RCON [10] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                                         8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};

    logic         clk;
    logic         rst_n;
    logic [127:0] key_in;
    logic         key_valid;
    logic         key_ready;
    logic         busy;
    logic         keys_done;
    logic [3:0]   rd_idx;
    logic [127:0] rd_key;
    logic         rd_valid;

    int           vectorCount;
    int           failCount;
    logic [7:0]   sboxTab [0:255];
    logic [127:0] expRk [0:10];

    aes_key_schedule dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .key_in    (key_in),
        .key_valid (key_valid),
        .key_ready (key_ready),
        .busy      (busy),
        .keys_done (keys_done),
        .rd_idx    (rd_idx),
        .rd_key    (rd_key),
        .rd_valid  (rd_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [127:0] got, input logic [127:0] exp);
        vectorCount++;
        if (got !== exp) begin
            failCount++;
            $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // S-box table built by walking the multiplicative group with generator 3.
    task automatic buildSbox();
        logic [7:0] p, q, x;
        p = 8'h01;
        q = 8'h01;
        do begin
            p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
            q = q ^ {q[6:0], 1'b0};
            q = q ^ {q[5:0], 2'b0};
            q = q ^ {q[3:0], 4'b0};
            if (q[7]) q = q ^ 8'h09;
            x = q ^ {q[6:0], q[7]} ^ {q[5:0], q[7:6]} ^ {q[4:0], q[7:5]} ^ {q[3:0], q[7:4]};
            sboxTab[p] = x ^ 8'h63;
        end while (p != 8'h01);
        sboxTab[0] = 8'h63;
    endtask

    task automatic computeModel(input logic [127:0] key);
        logic [31:0] w [0:43];
        logic [31:0] t;
        for (int i = 0; i < 4; i++) w[i] = key[127 - 32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sboxTab[t[31:24]], sboxTab[t[23:16]], sboxTab[t[15:8]], sboxTab[t[7:0]]};
                t = t ^ {RCON[i/4 - 1], 24'h0};
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r < 11; r++) expRk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    task automatic applyStimulus(input logic [127:0] key);
        key_in    = key;
        key_valid = 1'b1;
        @(posedge clk);
        #1;
        key_valid = 1'b0;
    endtask

    task automatic readKey(input logic [3:0] idx, output logic [127:0] k, output logic v);
        rd_idx = idx;
        if (LAT != 0) @(posedge clk);
        @(negedge clk);
        k = rd_key;
        v = rd_valid;
    endtask

    task automatic waitDone();
        int cycles;
        cycles = 0;
        while (!keys_done && cycles < 20) begin
            @(posedge clk);
            #1;
            cycles++;
        end
        checkOutput("doneLatency", 128'(cycles), 128'(10));
    endtask

    task automatic checkAll();
        logic [127:0] k;
        logic         v;
        for (int i = 0; i < 11; i++) begin
            readKey(4'(i), k, v);
            checkOutput($sformatf("rk%0d", i), k, expRk[i]);
            checkOutput($sformatf("rkValid%0d", i), 128'(v), 128'(1));
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [127:0] k, keyA, keyB, zeroRk10;
        logic         v;
        vectorCount = 0;
        failCount   = 0;
        buildSbox();
        rst_n     = 1'b0;
        key_in    = '0;
        key_valid = 1'b0;
        rd_idx    = 4'd0;
        #7;
        checkOutput("rstKeyReady", 128'(key_ready), 128'(1));
        checkOutput("rstBusy", 128'(busy), 128'(0));
        checkOutput("rstKeysDone", 128'(keys_done), 128'(0));
        checkOutput("rstRdValid", 128'(rd_valid), 128'(0));
        checkOutput("rstRdKey", rd_key, 128'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // FIPS-197 vector with cycle-by-cycle status and progressive rd_valid on index 3
        computeModel(128'h2b7e151628aed2a6abf7158809cf4f3c);
        checkOutput("modelRk1", expRk[1], 128'ha0fafe1788542cb123a339392a6c7605);
        checkOutput("modelRk10", expRk[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
        rd_idx = 4'd3;
        applyStimulus(128'h2b7e151628aed2a6abf7158809cf4f3c);
        checkOutput("loadBusy", 128'(busy), 128'(1));
        checkOutput("loadKeyReady", 128'(key_ready), 128'(0));
        checkOutput("loadValid3", 128'(rd_valid), 128'(0));
        for (int c = 1; c <= 10; c++) begin
            @(posedge clk);
            #1;
            checkOutput($sformatf("busyC%0d", c), 128'(busy), 128'(c < 10));
            checkOutput($sformatf("doneC%0d", c), 128'(keys_done), 128'(c == 10));
            checkOutput($sformatf("valid3C%0d", c), 128'(rd_valid), 128'(c >= 3 + LAT));
            if (c == 3 + LAT) checkOutput("rk3Early", rd_key, expRk[3]);
        end
        checkAll();
        readKey(4'd1, k, v);
        checkOutput("fipsRk1", k, 128'ha0fafe1788542cb123a339392a6c7605);
        readKey(4'd10, k, v);
        checkOutput("fipsRk10", k, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

        for (int i = 11; i < 16; i++) begin
            readKey(4'(i), k, v);
            checkOutput($sformatf("oobKey%0d", i), k, 128'h0);
            checkOutput($sformatf("oobValid%0d", i), 128'(v), 128'(0));
        end

        // second key held valid during expansion must be ignored until DONE
        keyA = {$urandom, $urandom, $urandom, $urandom};
        keyB = {$urandom, $urandom, $urandom, $urandom};
        computeModel(keyA);
        applyStimulus(keyA);
        key_in    = keyB;
        key_valid = 1'b1;
        checkOutput("ignoreKeyReady", 128'(key_ready), 128'(0));
        waitDone();
        key_valid = 1'b0;
        checkAll();
        computeModel(keyB);
        applyStimulus(keyB);
        waitDone();
        checkAll();

        // asynchronous reset mid-expansion
        keyA = {$urandom, $urandom, $urandom, $urandom};
        applyStimulus(keyA);
        repeat (4) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        checkOutput("abortKeyReady", 128'(key_ready), 128'(1));
        checkOutput("abortBusy", 128'(busy), 128'(0));
        checkOutput("abortKeysDone", 128'(keys_done), 128'(0));
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 11; i++) begin
            readKey(4'(i), k, v);
            checkOutput($sformatf("abortKey%0d", i), k, 128'h0);
            checkOutput($sformatf("abortValid%0d", i), 128'(v), 128'(0));
        end
        computeModel(keyA);
        applyStimulus(keyA);
        waitDone();
        checkAll();

        // back-to-back: zero key, then all-ones key loaded while round 10 is read
        computeModel(128'h0);
        zeroRk10 = expRk[10];
        checkOutput("modelZeroRk10", zeroRk10, 128'hb4ef5bcb3e92e21123e951cf6f8f188e);
        applyStimulus(128'h0);
        waitDone();
        rd_idx    = 4'd10;
        key_in    = {128{1'b1}};
        key_valid = 1'b1;
        if (LAT == 0) begin
            #2;
            checkOutput("zeroRk10", rd_key, zeroRk10);
            checkOutput("zeroRk10Valid", 128'(rd_valid), 128'(1));
            @(posedge clk);
            #1;
            key_valid = 1'b0;
            checkOutput("reloadValid10", 128'(rd_valid), 128'(0));
        end else begin
            @(posedge clk);
            #1;
            key_valid = 1'b0;
            checkOutput("zeroRk10", rd_key, zeroRk10);
            checkOutput("zeroRk10Valid", 128'(rd_valid), 128'(1));
        end
        computeModel({128{1'b1}});
        waitDone();
        checkAll();

        repeat (3) begin
            keyA = {$urandom, $urandom, $urandom, $urandom};
            computeModel(keyA);
            applyStimulus(keyA);
            waitDone();
            checkAll();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectorCount, failCount);
        $finish;
    end
endmodule
